// File: rtl/pe_operand_feeder.sv
// Operand feeder for one PE: streams input-activation and weight words from two
// single-cycle buffer read ports into the PE over two independent rdy/ack channels.
module pe_operand_feeder #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [LW-1:0] i_Pch,
  input  logic [LW-1:0] i_R,
  input  logic [LW-1:0] i_Pm,
  input  logic [AW-1:0] i_in_base,
  input  logic [AW-1:0] i_w_base,
  output logic          o_in_re,
  output logic [AW-1:0] o_in_addr,
  input  logic [DW-1:0] i_in_rdata,
  output logic          o_w_re,
  output logic [AW-1:0] o_w_addr,
  input  logic [DW-1:0] i_w_rdata,
  output logic          Input_rdy,
  input  logic          Input_ack,
  output logic [DW-1:0] Input_dat,
  output logic          Weight_rdy,
  input  logic          Weight_ack,
  output logic [DW-1:0] Weight_dat,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned CW = 3 * LW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Channel index 0 is Input, 1 is Weight.
  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_n      [2];
  logic [CW-1:0] r_rd_cnt [2];
  logic [CW-1:0] r_tx_cnt [2];
  logic [AW-1:0] r_addr   [2];
  logic [1:0]    r_occ    [2];
  logic [DW-1:0] r_head   [2];
  logic [DW-1:0] r_tail   [2];
  logic [1:0]    r_infl;

  logic [1:0]    w_ack;
  logic [1:0]    w_rdy;
  logic [1:0]    w_pop;
  logic [1:0]    w_re;
  logic [DW-1:0] w_rdata  [2];
  logic [CW-1:0] w_n_in;
  logic [CW-1:0] w_n_w;
  logic          w_fin;

  // Issue/transfer decisions. An entry popped this cycle frees its FIFO slot for
  // the read issued now, which is what lets a channel stream one word per cycle.
  always_comb begin
    w_ack      = {Weight_ack, Input_ack};
    w_rdata[0] = i_in_rdata;
    w_rdata[1] = i_w_rdata;
    w_n_in     = CW'(i_Pch) * CW'(i_R);
    w_n_w      = w_n_in * CW'(i_Pm);
    w_rdy      = '0;
    w_pop      = '0;
    w_re       = '0;
    w_fin      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      w_rdy[c] = (r_occ[c] != 2'd0);
      w_pop[c] = w_rdy[c] & w_ack[c];
      w_re[c]  = (r_state == S_LOAD) && (r_rd_cnt[c] < r_n[c]) &&
                 ((3'(r_occ[c]) + 3'(r_infl[c]) - 3'(w_pop[c])) < 3'd2);
      if ((r_tx_cnt[c] + CW'(w_pop[c])) != r_n[c]) w_fin = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_infl  <= '0;
      for (int c = 0; c < 2; c++) begin
        r_n[c]      <= '0;
        r_rd_cnt[c] <= '0;
        r_tx_cnt[c] <= '0;
        r_addr[c]   <= '0;
        r_occ[c]    <= '0;
        r_head[c]   <= '0;
        r_tail[c]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_n[0]  <= w_n_in;
            r_n[1]  <= w_n_w;
            r_addr[0] <= i_in_base;
            r_addr[1] <= i_w_base;
            r_infl  <= '0;
            for (int c = 0; c < 2; c++) begin
              r_rd_cnt[c] <= '0;
              r_tx_cnt[c] <= '0;
              r_occ[c]    <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_fin) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Per-channel read pipeline and 2-entry FIFO (head drives dat).
      if (r_state == S_LOAD) begin
        for (int c = 0; c < 2; c++) begin
          r_infl[c] <= w_re[c];
          if (w_re[c]) begin
            r_rd_cnt[c] <= r_rd_cnt[c] + CW'(1);
            r_addr[c]   <= r_addr[c] + AW'(1);
          end
          if (w_pop[c]) r_tx_cnt[c] <= r_tx_cnt[c] + CW'(1);
          case ({r_infl[c], w_pop[c]})
            2'b10: begin
              if (r_occ[c] == 2'd0) r_head[c] <= w_rdata[c];
              else                  r_tail[c] <= w_rdata[c];
              r_occ[c] <= r_occ[c] + 2'd1;
            end
            2'b01: begin
              r_head[c] <= r_tail[c];
              r_occ[c]  <= r_occ[c] - 2'd1;
            end
            2'b11: begin
              if (r_occ[c] == 2'd1) begin
                r_head[c] <= w_rdata[c];
              end else begin
                r_head[c] <= r_tail[c];
                r_tail[c] <= w_rdata[c];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  a_cnt_bounds: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_rd_cnt[0] <= r_n[0]) && (r_tx_cnt[0] <= r_rd_cnt[0]) &&
    (r_rd_cnt[1] <= r_n[1]) && (r_tx_cnt[1] <= r_rd_cnt[1]));

  assign o_in_re    = w_re[0];
  assign o_in_addr  = r_addr[0];
  assign o_w_re     = w_re[1];
  assign o_w_addr   = r_addr[1];
  assign Input_rdy  = w_rdy[0];
  assign Input_dat  = r_head[0];
  assign Weight_rdy = w_rdy[1];
  assign Weight_dat = r_head[1];
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder: a job-level model queues expected
// addresses and words; a negedge monitor pops and compares as the DUT presents them.
module tb_pe_operand_feeder;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 10;
  localparam int unsigned LW  = 6;
  localparam int unsigned MEM = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_Pch = '0, i_R = '0, i_Pm = '0;
  logic [AW-1:0] i_in_base = '0, i_w_base = '0;
  logic          o_in_re, o_w_re;
  logic [AW-1:0] o_in_addr, o_w_addr;
  logic [DW-1:0] i_in_rdata = '0, i_w_rdata = '0;
  logic          Input_rdy, Weight_rdy;
  logic          Input_ack = 1'b0, Weight_ack = 1'b0;
  logic [DW-1:0] Input_dat, Weight_dat;
  logic          o_busy, o_done;

  always #5 i_clk = ~i_clk;

  pe_operand_feeder #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_Pch(i_Pch), .i_R(i_R), .i_Pm(i_Pm),
    .i_in_base(i_in_base), .i_w_base(i_w_base),
    .o_in_re(o_in_re), .o_in_addr(o_in_addr), .i_in_rdata(i_in_rdata),
    .o_w_re(o_w_re), .o_w_addr(o_w_addr), .i_w_rdata(i_w_rdata),
    .Input_rdy(Input_rdy), .Input_ack(Input_ack), .Input_dat(Input_dat),
    .Weight_rdy(Weight_rdy), .Weight_ack(Weight_ack), .Weight_dat(Weight_dat),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Buffers with single-cycle read latency.
  logic [DW-1:0] mem_in [MEM];
  logic [DW-1:0] mem_w  [MEM];
  always @(posedge i_clk) begin
    if (o_in_re) i_in_rdata <= mem_in[o_in_addr];
    if (o_w_re)  i_w_rdata  <= mem_w[o_w_addr];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Scoreboard state
  logic [DW-1:0] exp_in_dat[$], exp_w_dat[$];
  logic [AW-1:0] exp_in_addr[$], exp_w_addr[$];
  int start_cyc = 0, last_tx_cyc = 0, done_cnt = 0, busy_cnt = 0;
  int n_in_rd = 0, n_in_tx = 0, n_w_rd = 0, n_w_tx = 0;
  bit in_first = 0, w_first = 0, in_hold = 0, w_hold = 0, mon_en = 0;
  logic [DW-1:0] in_hold_dat = '0, w_hold_dat = '0;
  int ack_mode = 0;

  // PE-side acknowledge driver
  initial forever begin
    @(posedge i_clk); #1;
    case (ack_mode)
      0: begin Input_ack = 1'b1; Weight_ack = 1'b1; end
      1: begin Input_ack = 1'($urandom_range(0, 1)); Weight_ack = 1'($urandom_range(0, 1)); end
      default: begin
        Weight_ack = ((cyc - start_cyc) % 2) == 0;
        Input_ack  = (cyc - start_cyc) >= 13;
      end
    endcase
  end

  // Monitor: compares everything the DUT presents against the queued expectations.
  initial forever begin
    @(negedge i_clk);
    if (mon_en && !i_rst) begin
      if (o_busy) busy_cnt++;
      if (in_hold) begin
        chk("in_stall_rdy", 64'(Input_rdy), 64'(1));
        chk("in_stall_dat", 64'(Input_dat), 64'(in_hold_dat));
      end
      if (w_hold) begin
        chk("w_stall_rdy", 64'(Weight_rdy), 64'(1));
        chk("w_stall_dat", 64'(Weight_dat), 64'(w_hold_dat));
      end
      if (Input_rdy) begin
        chk("in_rdy_expected", 64'(exp_in_dat.size() > 0), 64'(1));
        if (!in_first) chk("in_first_rdy_cycle", 64'(cyc), 64'(start_cyc + 3));
        in_first = 1;
      end
      if (Weight_rdy) begin
        chk("w_rdy_expected", 64'(exp_w_dat.size() > 0), 64'(1));
        if (!w_first) chk("w_first_rdy_cycle", 64'(cyc), 64'(start_cyc + 3));
        w_first = 1;
      end
      if (Input_rdy && Input_ack) begin
        if (exp_in_dat.size() > 0) chk("in_dat", 64'(Input_dat), 64'(exp_in_dat.pop_front()));
        n_in_tx++;
        last_tx_cyc = cyc;
      end
      if (Weight_rdy && Weight_ack) begin
        if (exp_w_dat.size() > 0) chk("w_dat", 64'(Weight_dat), 64'(exp_w_dat.pop_front()));
        n_w_tx++;
        last_tx_cyc = cyc;
      end
      if (o_in_re) begin
        n_in_rd++;
        if (exp_in_addr.size() > 0) chk("in_addr", 64'(o_in_addr), 64'(exp_in_addr.pop_front()));
        else chk("in_re_expected", 64'(0), 64'(1));
        chk("in_outstanding_le2", 64'((n_in_rd - n_in_tx) <= 2), 64'(1));
      end
      if (o_w_re) begin
        n_w_rd++;
        if (exp_w_addr.size() > 0) chk("w_addr", 64'(o_w_addr), 64'(exp_w_addr.pop_front()));
        else chk("w_re_expected", 64'(0), 64'(1));
        chk("w_outstanding_le2", 64'((n_w_rd - n_w_tx) <= 2), 64'(1));
      end
      in_hold = Input_rdy && !Input_ack;   in_hold_dat = Input_dat;
      w_hold  = Weight_rdy && !Weight_ack; w_hold_dat  = Weight_dat;
      if (o_done) begin
        done_cnt++;
        chk("done_cycle", 64'(cyc), 64'(last_tx_cyc + 1));
        chk("busy_cycles", 64'(busy_cnt), 64'(cyc - start_cyc));
        chk("in_all_sent", 64'(exp_in_dat.size()), 64'(0));
        chk("w_all_sent", 64'(exp_w_dat.size()), 64'(0));
      end
    end
  end

  // Reference model: a job is just two linear address streams of Pch*R and Pch*R*Pm words.
  task automatic start_job(input int pch, input int r, input int pm, input int inb, input int wb);
    logic [AW-1:0] a;
    for (int k = 0; k < pch * r; k++) begin
      a = AW'(inb + k);
      exp_in_addr.push_back(a);
      exp_in_dat.push_back(mem_in[a]);
    end
    for (int k = 0; k < pch * r * pm; k++) begin
      a = AW'(wb + k);
      exp_w_addr.push_back(a);
      exp_w_dat.push_back(mem_w[a]);
    end
    done_cnt = 0; busy_cnt = 0;
    n_in_rd = 0; n_in_tx = 0; n_w_rd = 0; n_w_tx = 0;
    in_first = 0; w_first = 0; in_hold = 0; w_hold = 0;
    start_cyc = cyc; last_tx_cyc = cyc + 1;
    i_start = 1'b1;
    i_Pch = LW'(pch); i_R = LW'(r); i_Pm = LW'(pm);
    i_in_base = AW'(inb); i_w_base = AW'(wb);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_Pch = LW'($urandom); i_R = LW'($urandom); i_Pm = LW'($urandom);
    i_in_base = AW'($urandom); i_w_base = AW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 64'(0), 64'(1));
    repeat (3) begin @(posedge i_clk); #1; end
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("busy_after_done", 64'(o_busy), 64'(0));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge i_clk); #1; end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_in_re, o_in_addr, o_w_re, o_w_addr, Input_rdy, Input_dat,
                Weight_rdy, Weight_dat, o_busy, o_done});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(MEM); i++) begin
      mem_in[i] = DW'($urandom);
      mem_w[i]  = DW'($urandom);
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_outputs", all_outs(), 64'(0));
    i_rst = 1'b0;
    mon_en = 1;
    @(posedge i_clk); #1;

    // Basic job, continuous ack
    ack_mode = 0;
    start_job(2, 3, 2, 'h010, 'h100);
    wait_done(200);

    // Same job with Input stalled and Weight ack toggling
    ack_mode = 2;
    start_job(2, 3, 2, 'h010, 'h100);
    wait_until(start_cyc + 12);
    @(negedge i_clk);
    chk("stall_in_reads", 64'(n_in_rd), 64'(2));
    chk("stall_in_tx", 64'(n_in_tx), 64'(0));
    chk("stall_in_rdy", 64'(Input_rdy), 64'(1));
    @(posedge i_clk); #1;
    wait_done(300);

    // Weight address wrap past the top of the buffer
    ack_mode = 1;
    start_job(1, 2, 2, int'($urandom_range(0, MEM - 1)), 'h3FE);
    wait_done(300);

    // Zero extent: no reads, no rdy, done two cycles after start
    start_job(0, 3, 2, 'h020, 'h200);
    wait_done(50);
    chk("zero_done_cycle", 64'(last_tx_cyc + 1), 64'(start_cyc + 2));

    // Reset in the middle of a 12-word job, then a 1x1x1 job from new bases
    ack_mode = 0;
    start_job(2, 3, 2, 'h040, 'h140);
    wait_until(start_cyc + 5);
    chk("mid_infl_before_rst", 64'(o_in_re | o_w_re), 64'(1));
    i_rst = 1'b1;
    #1;
    chk("mid_rst_outputs", all_outs(), 64'(0));
    exp_in_dat.delete(); exp_w_dat.delete(); exp_in_addr.delete(); exp_w_addr.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    start_job(1, 1, 1, 'h2A0, 'h333);
    wait_done(50);
    chk("post_rst_in_words", 64'(n_in_tx), 64'(1));
    chk("post_rst_w_words", 64'(n_w_tx), 64'(1));

    // Start re-pulsed during LOAD must be ignored
    ack_mode = 1;
    start_job(2, 2, 3, 'h0F0, 'h1F0);
    wait_until(start_cyc + 4);
    chk("repulse_busy", 64'(o_busy), 64'(1));
    i_start = 1'b1; i_Pch = LW'(5); i_R = LW'(5); i_Pm = LW'(5);
    i_in_base = AW'('h300); i_w_base = AW'('h000);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(400);
    chk("repulse_w_words", 64'(n_w_tx), 64'(12));

    // Randomized jobs
    for (int j = 0; j < 4; j++) begin
      start_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, MEM - 1)),
                int'($urandom_range(0, MEM - 1)));
      wait_done(1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
